soc_system_pio_scan_ctrl: RTL and testbench
===========================================

// Module: soc_system_pio_scan_ctrl
// PURPOSE
//   Scheduler that sequences periodic reads of NUM_CH input-PIO data registers over one shared
//   read path (channel select + fixed 1-cycle read latency, data register at address 0).
//   Scans channels 0..NUM_CH-1 in order, presents each sample as a one-cycle valid beat and
//   flags changes against a per-channel shadow copy. Sits between the PIO bank and FPGA-side
//   consumers; the HPS never polls the PIOs itself.
// PARAMETERS
//   NUM_CH   4    number of PIO channels scanned, >= 2; CH_W = $clog2(NUM_CH)
//   DATA_W   32   PIO data width
//   DIV_W    16   width of scan period counter
// PORTS
//   clk          in   1          system clock; all logic on posedge
//   reset_n      in   1          asynchronous, active-low reset
//   enable       in   1          level; 1 = run periodic scans
//   period       in   DIV_W      scan start-to-start interval in clk cycles; sampled at scan start
//   m_chan       out  CH_W       channel select to PIO read mux
//   m_address    out  2          PIO register address; constant 2'b00 (data register)
//   m_read       out  1          read strobe, one cycle per channel
//   m_readdata   in   DATA_W     PIO readdata; valid the cycle after m_read
//   out_valid    out  1          one-cycle pulse: out_value/out_ch/out_changed valid
//   out_ch       out  CH_W       channel index of current sample
//   out_value    out  DATA_W     sampled value
//   out_changed  out  1          value differs from shadow, or first sample since reset
//   scan_done    out  1          one-cycle pulse coincident with last channel's out_valid
//   busy         out  1          1 while a scan is in progress (ISSUE/CAPTURE states)
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE; all outputs 0; period counter 0; shadow regs 0;
//   seen[NUM_CH-1:0]=0. Reset mid-scan aborts immediately; no partial out_valid after release.
// - FSM: IDLE -> ISSUE (enable=1) ; ISSUE -> CAPTURE (always) ;
//   CAPTURE -> ISSUE (ch<NUM_CH-1, ch++) ; CAPTURE -> WAIT (last ch, enable=1) ;
//   CAPTURE -> IDLE (last ch, enable=0) ; WAIT -> ISSUE when period counter expires, -> IDLE if enable=0.
// - ISSUE cycle T: m_read=1, m_chan=ch. CAPTURE cycle T+1: m_readdata sampled at end of T+1.
//   Cycle T+2: out_valid=1, out_ch=ch, out_value=sample. Latency m_read -> out_valid = 2 cycles.
// - Scan length 2*NUM_CH cycles; m_read never asserted on consecutive cycles.
// - Period: counter loaded with period at ISSUE of channel 0, decrements each cycle, saturates at 0.
//   Next scan ISSUE occurs at scan start + max(period, 2*NUM_CH); period < 2*NUM_CH (incl. 0)
//   gives back-to-back scans with no idle cycle. No scan overlap ever.
// - Change detect: out_changed = !seen[ch] | (sample != shadow[ch]); shadow[ch]<=sample,
//   seen[ch]<=1 on every capture. Full DATA_W compare, no masking.
// - enable: rising edge in IDLE starts a scan the next cycle; falling edge mid-scan lets the
//   scan complete (all NUM_CH samples delivered), then IDLE. enable changes mid-scan are
//   otherwise ignored. period changes take effect at the next scan start only.
// - m_chan holds last value outside ISSUE; m_address tied 2'b00; busy=0 in IDLE and WAIT.
// - No backpressure: consumers must accept out_valid beats every other cycle.
// TESTING
//   1 Assert reset_n=0 mid-activity -> all outputs 0 asynchronously; after release, no
//     out_valid until enable=1.
//   2 NUM_CH=4, readdata per ch = 32'h11,22,33,44, enable=1, period=100 -> 4 out_valid pulses
//     2 cycles apart, ch 0..3, out_changed=1 each, scan_done with ch3, next scan 100 cycles later.
//   3 Second scan with ch2 changed to 32'h35 -> out_changed=1 only for ch2, others 0.
//   4 period=0 -> m_read every 2nd cycle continuously, scan_done every 8 cycles, no gaps.
//   5 Drop enable after ch1 issue -> ch2, ch3 still delivered, then IDLE, busy=0, no further m_read.
//   6 Change period 100->20 mid-scan -> current interval stays 100; following interval 20.

Source files
------------

// File: rtl/soc_system_pio_scan_ctrl.sv
// Periodic scanner for a bank of input PIOs sharing one read path.
// Issues one read per channel (read strobe every other cycle), returns each sample
// as a single-cycle beat two cycles after its read, and flags changes against a
// per-channel shadow copy. Scans restart every max(period, 2*NUM_CH) cycles.
module soc_system_pio_scan_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIV_W  = 16,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  period,
  output logic [CH_W-1:0]   m_chan,
  output logic [1:0]        m_address,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_readdata,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_value,
  output logic              out_changed,
  output logic              scan_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     w_ch_next;
  logic [DIV_W-1:0]    r_cnt;
  logic [NUM_CH-1:0]   r_seen;
  logic [DATA_W-1:0]   r_shadow [NUM_CH];
  logic                r_m_read;
  logic [CH_W-1:0]     r_m_chan;
  logic                r_busy;
  logic                r_out_valid;
  logic [CH_W-1:0]     r_out_ch;
  logic [DATA_W-1:0]   r_out_value;
  logic                r_out_changed;
  logic                r_scan_done;

  logic w_last;
  logic w_expire;
  logic w_cap;

  assign w_last = (r_ch == CH_W'(NUM_CH - 1));
  // The counter is loaded during the ch0 ISSUE cycle and has already stepped once
  // by the time of the decision, and the new ISSUE lands one cycle after it:
  // a value of 2 or less at the decision cycle means the interval is used up.
  assign w_expire = (r_cnt <= DIV_W'(2));
  assign w_cap    = (r_state == S_CAPTURE);

  // Next-state and channel sequencing
  always_comb begin
    w_next    = r_state;
    w_ch_next = r_ch;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_next    = S_ISSUE;
          w_ch_next = '0;
        end
      end
      S_ISSUE: begin
        w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!w_last) begin
          w_next    = S_ISSUE;
          w_ch_next = r_ch + CH_W'(1);
        end else if (!enable) begin
          w_next = S_IDLE;
        end else if (w_expire) begin
          w_next    = S_ISSUE;
          w_ch_next = '0;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if (w_expire) begin
          w_next    = S_ISSUE;
          w_ch_next = '0;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, channel and period counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_ch    <= w_ch_next;
      if ((r_state == S_ISSUE) && (r_ch == '0)) begin
        r_cnt <= period;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end
  end

  // Read-side outputs, registered from the next state so they align with ISSUE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_read <= 1'b0;
      r_m_chan <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_m_read <= (w_next == S_ISSUE);
      r_busy   <= (w_next == S_ISSUE) || (w_next == S_CAPTURE);
      if (w_next == S_ISSUE) begin
        r_m_chan <= w_ch_next;
      end
    end
  end

  // Sample capture, change detection and shadow update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_ch      <= '0;
      r_out_value   <= '0;
      r_out_changed <= 1'b0;
      r_scan_done   <= 1'b0;
      r_seen        <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_out_valid <= w_cap;
      r_scan_done <= w_cap && w_last;
      if (w_cap) begin
        r_out_ch      <= r_ch;
        r_out_value   <= m_readdata;
        r_out_changed <= !r_seen[r_ch] || (m_readdata != r_shadow[r_ch]);
        r_shadow[r_ch] <= m_readdata;
        r_seen[r_ch]   <= 1'b1;
      end
    end
  end

  assign m_address   = 2'b00;
  assign m_read      = r_m_read;
  assign m_chan      = r_m_chan;
  assign busy        = r_busy;
  assign out_valid   = r_out_valid;
  assign out_ch      = r_out_ch;
  assign out_value   = r_out_value;
  assign out_changed = r_out_changed;
  assign scan_done   = r_scan_done;

endmodule

// File: tb/tb_soc_system_pio_scan_ctrl.sv
// Self-checking bench for soc_system_pio_scan_ctrl: directed scenarios followed by
// randomized enable/period/data/reset activity, all checked against a scan-level model.
module tb_soc_system_pio_scan_ctrl;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned CH_W   = 2;
  localparam int SCAN_LEN = 2 * NUM_CH;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [DIV_W-1:0]  period = '0;
  logic [DATA_W-1:0] m_readdata = '0;
  logic [CH_W-1:0]   m_chan;
  logic [1:0]        m_address;
  logic              m_read;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_value;
  logic              out_changed;
  logic              scan_done;
  logic              busy;

  soc_system_pio_scan_ctrl #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .period      (period),
    .m_chan      (m_chan),
    .m_address   (m_address),
    .m_read      (m_read),
    .m_readdata  (m_readdata),
    .out_valid   (out_valid),
    .out_ch      (out_ch),
    .out_value   (out_value),
    .out_changed (out_changed),
    .scan_done   (scan_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scan-level reference model: a scan occupies 2*NUM_CH cycles starting at s,
  // with reads on even offsets; each read's data appears two cycles later.
  typedef enum int {M_IDLE, M_SCAN, M_WAIT} mode_t;
  mode_t             mode = M_IDLE;
  int                cyc = 0;
  int                s = 0;
  int                p = SCAN_LEN;
  bit                exp_read = 1'b0;
  int                exp_chan = 0;
  bit                rd1 = 1'b0;
  bit                rd2 = 1'b0;
  int                ch1 = 0;
  int                ch2 = 0;
  bit                exp_valid = 1'b0;
  bit                exp_done = 1'b0;
  bit                exp_chg = 1'b0;
  int                exp_och = 0;
  logic [DATA_W-1:0] exp_val = '0;
  bit                seen   [NUM_CH];
  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [DATA_W-1:0] pio    [NUM_CH];
  logic [DATA_W-1:0] sn_pio [NUM_CH];
  bit                sn_rst = 1'b0;
  bit                sn_en = 1'b0;
  int                sn_per = 0;

  task automatic model_reset();
    mode      = M_IDLE;
    exp_read  = 1'b0;
    exp_chan  = 0;
    rd1       = 1'b0;
    rd2       = 1'b0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      seen[i]   = 1'b0;
      shadow[i] = '0;
    end
  endtask

  task automatic advance();
    int prev;
    bit prev_read;
    int prev_ch;
    prev      = cyc;
    cyc       = cyc + 1;
    prev_read = exp_read;
    prev_ch   = exp_chan;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (!sn_rst) begin
      model_reset();
      return;
    end
    if (mode == M_SCAN && prev == s) p = (sn_per > SCAN_LEN) ? sn_per : SCAN_LEN;
    case (mode)
      M_IDLE: if (sn_en) begin mode = M_SCAN; s = cyc; end
      M_SCAN: begin
        if (prev == s + SCAN_LEN - 1) begin
          if (!sn_en)          mode = M_IDLE;
          else if (cyc == s + p) s = cyc;
          else                 mode = M_WAIT;
        end
      end
      M_WAIT: begin
        if (!sn_en)            mode = M_IDLE;
        else if (cyc == s + p) begin mode = M_SCAN; s = cyc; end
      end
      default: mode = M_IDLE;
    endcase
    exp_read = (mode == M_SCAN) && (((cyc - s) % 2) == 0);
    if (exp_read) exp_chan = (cyc - s) / 2;
    rd2 = rd1; ch2 = ch1;
    rd1 = prev_read; ch1 = prev_ch;
    if (rd2) begin
      exp_valid   = 1'b1;
      exp_och     = ch2;
      exp_val     = sn_pio[ch2];
      exp_chg     = !seen[ch2] || (exp_val != shadow[ch2]);
      seen[ch2]   = 1'b1;
      shadow[ch2] = exp_val;
      exp_done    = (ch2 == NUM_CH - 1);
    end
  endtask

  task automatic compare();
    check("m_read",    64'(m_read),    64'(exp_read));
    check("m_chan",    64'(m_chan),    64'(exp_chan));
    check("m_address", 64'(m_address), 64'(0));
    check("busy",      64'(busy),      64'(mode == M_SCAN));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("scan_done", 64'(scan_done), 64'(exp_done));
    if (exp_valid) begin
      check("out_ch",      64'(out_ch),      64'(exp_och));
      check("out_value",   64'(out_value),   64'(exp_val));
      check("out_changed", 64'(out_changed), 64'(exp_chg));
    end
  endtask

  // One clock: PIO mux answers at the falling edge, model and checks after the rising edge
  task automatic tick();
    @(negedge clk);
    m_readdata = pio[m_chan];
    sn_rst = reset_n;
    sn_en  = enable;
    sn_per = int'(period);
    sn_pio = pio;
    @(posedge clk);
    #1;
    advance();
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset between edges and confirm outputs clear without a clock
  task automatic async_reset_check();
    reset_n = 1'b0;
    #1;
    check("rst_m_read",      64'(m_read),      64'(0));
    check("rst_m_chan",      64'(m_chan),      64'(0));
    check("rst_busy",        64'(busy),        64'(0));
    check("rst_out_valid",   64'(out_valid),   64'(0));
    check("rst_out_ch",      64'(out_ch),      64'(0));
    check("rst_out_value",   64'(out_value),   64'(0));
    check("rst_out_changed", 64'(out_changed), 64'(0));
    check("rst_scan_done",   64'(scan_done),   64'(0));
    model_reset();
  endtask

  task automatic wait_read_ch(input int ch, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (exp_read && exp_chan == ch) found = 1'b1;
    end
    if (!found) check(tag, 64'(0), 64'(1));
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) pio[i] = '0;
    model_reset();

    // Reset, then reset mid-scan, then no beats until enabled
    ticks(3);
    reset_n = 1'b1;
    ticks(2);
    pio[0] = 32'hA5; pio[1] = 32'h5A; pio[2] = 32'h77; pio[3] = 32'h88;
    period = DIV_W'(50);
    enable = 1'b1;
    ticks(5);
    async_reset_check();
    enable = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(10);

    // First scans: all changed, then only ch2 changes
    pio[0] = 32'h11; pio[1] = 32'h22; pio[2] = 32'h33; pio[3] = 32'h44;
    period = DIV_W'(100);
    enable = 1'b1;
    ticks(60);
    pio[2] = 32'h35;
    ticks(150);

    // period 0: back-to-back scans
    period = '0;
    ticks(150);

    // Drop enable after ch1 issue: scan finishes, then idle
    wait_read_ch(1, "wait_ch1_issue");
    enable = 1'b0;
    ticks(30);

    // Period change mid-scan affects only the following interval
    period = DIV_W'(100);
    enable = 1'b1;
    ticks(4);
    period = DIV_W'(20);
    ticks(250);

    // Randomized activity
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39, 0) == 0) enable = ~enable;
      if ($urandom_range(29, 0) == 0) period = DIV_W'($urandom_range(40, 0));
      if ($urandom_range(5, 0) == 0) begin
        pio[$urandom_range(NUM_CH - 1, 0)] =
          ($urandom_range(1, 0) == 0) ? DATA_W'($urandom_range(3, 0)) : DATA_W'($urandom);
      end
      if ($urandom_range(499, 0) == 0) begin
        async_reset_check();
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
